// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result bundle for pipelined_addsub.
// The master side supplies operands and accepts results; the slave side is the adder.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op1, op2, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, op1, op2, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: the WIDTH-bit carry chain is cut into STAGES
// segments of WIDTH/STAGES bits, one segment added per cycle, with a global
// stall driven by the output handshake. The last stage is the output register
// and also produces the carry/overflow/zero flags.
// Optional feature: define ADDSUB_SAT_EN to clamp the result on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int MID  = (STAGES > 1) ? STAGES - 1 : 1;

  logic adv;

  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [SEG:0]     seg_sum[STAGES];
  logic [WIDTH-1:0] s_next [STAGES];

  logic [WIDTH-1:0] a_q [MID];
  logic [WIDTH-1:0] a_d [MID];
  logic [WIDTH-1:0] b_q [MID];
  logic [WIDTH-1:0] b_d [MID];
  logic [WIDTH-1:0] s_q [MID];
  logic [WIDTH-1:0] s_d [MID];
  logic             c_q [MID];
  logic             c_d [MID];
  logic             v_q [MID];
  logic             v_d [MID];

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_f;
  logic             ovf_f;

  assign adv           = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Stage inputs: stage 0 takes the (conditionally inverted) operands, later stages the previous register.
  always_comb begin
    a_in[0] = bus.op1;
    b_in[0] = bus.op2 ^ {WIDTH{bus.sub}};
    s_in[0] = '0;
    c_in[0] = bus.sub;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  // Segment adders: stage k adds bits of segment k and splices them into the partial result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};
      s_next[k] = s_in[k];
      s_next[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
  end

  // Intermediate stage registers advance together on adv and otherwise hold, bubbles included.
  always_comb begin
    for (int k = 0; k < MID; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      v_d[k] = v_q[k];
      if ((k < LAST) && adv) begin
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
        s_d[k] = s_next[k];
        c_d[k] = seg_sum[k][SEG];
        v_d[k] = v_in[k];
      end
    end
  end

  // Final stage: flags from the completed sum, optional clamp, then zero on the clamped value.
  always_comb begin
    ovf_f = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
            (s_next[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    res_f = s_next[LAST];
`ifdef ADDSUB_SAT_EN
    if (ovf_f) begin
      res_f = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
`endif
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    if (adv) begin
      out_valid_d = v_in[LAST];
      if (v_in[LAST]) begin
        result_d   = res_f;
        carry_d    = seg_sum[LAST][SEG];
        overflow_d = ovf_f;
        zero_d     = ~|res_f;
      end
    end
  end

  // Intermediate pipeline flops; reset discards every in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MID; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < MID; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  // Output register holding result and flags stable until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4).
// Honours ADDSUB_SAT_EN in its expectations when the macro is defined.
module tb_pipelined_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   popped;
  int   acc_cyc;
  exp_t exp_q[$];

  logic [31:0] str_a [8];
  logic [31:0] str_b [8];
  logic        str_s [8];

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock and cycle counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: exact integer arithmetic on the operands, independent of any pipeline structure.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [32:0] full;
    longint      exact;
    full  = {1'b0, a} + {1'b0, (s ? ~b : b)} + {32'd0, s};
    exact = s ? (longint'($signed(a)) - longint'($signed(b)))
              : (longint'($signed(a)) + longint'($signed(b)));
    e.c = full[32];
    e.r = full[31:0];
    e.v = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
    if (e.v) e.r = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: every cycle with out_valid the outputs must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output: got out_valid=1 r=%h, required no output pending", bus.result);
        end else begin
          if (bus.result !== exp_q[0].r || bus.carry !== exp_q[0].c ||
              bus.overflow !== exp_q[0].v || bus.zero !== exp_q[0].z) begin
            failures++;
            $display("[TB] FAIL model_compare: got r=%h c=%b v=%b z=%b, required r=%h c=%b v=%b z=%b",
                     bus.result, bus.carry, bus.overflow, bus.zero,
                     exp_q[0].r, exp_q[0].c, exp_q[0].v, exp_q[0].z);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op1, bus.op2, bus.sub));
    end
  end

  // Present one operation and hold it until accepted; records the acceptance cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit done;
    done = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.sub      = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done    = 1;
        acc_cyc = cyc;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result and compare against hand-computed literals and latency.
  task automatic checkOutput(input string name, input logic [31:0] er, input logic ec,
                             input logic ev, input logic ez);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s: got no out_valid within 50 cycles, required a result", name);
    end else begin
      if (bus.result !== er || bus.carry !== ec || bus.overflow !== ev || bus.zero !== ez) begin
        failures++;
        $display("[TB] FAIL %s: got r=%h c=%b v=%b z=%b, required r=%h c=%b v=%b z=%b",
                 name, bus.result, bus.carry, bus.overflow, bus.zero, er, ec, ev, ez);
      end
      checks++;
      if (cyc - acc_cyc != STAGES) begin
        failures++;
        $display("[TB] FAIL %s_latency: got %0d cycles, required %0d", name, cyc - acc_cyc, STAGES);
      end
    end
  endtask

  initial begin
    int   idx;
    int   base;
    int   rnd_acc;
    bit   accepted;
    logic exp_rdy;

    checks       = 0;
    failures     = 0;
    popped       = 0;
    cyc          = 0;
    acc_cyc      = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op1      = '0;
    bus.op2      = '0;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.carry !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got v=%b r=%h c=%b o=%b z=%b, required all zero",
               bus.out_valid, bus.result, bus.carry, bus.overflow, bus.zero);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    applyStimulus(32'd15, 32'd10, 1'b0);
    checkOutput("add_15_10", 32'd25, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("add_max_max", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'd1000, 32'd2000, 1'b1);
    checkOutput("sub_1000_2000", 32'hFFFF_FC18, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0);
    checkOutput("add_pos_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b1);
    checkOutput("sub_neg_ovf", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0);
    checkOutput("add_pos_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b1);
    checkOutput("sub_neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    applyStimulus(32'd5, 32'd5, 1'b1);
    checkOutput("sub_5_5", 32'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'd0, 32'd1, 1'b1);
    checkOutput("sub_0_1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h00FF_FFFF, 32'd1, 1'b0);
    checkOutput("seg_carry_chain", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    checkOutput("wrap_to_zero", 32'd0, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream of 8 ops with the consumer stalling in stream cycles 6..8.
    for (int j = 0; j < 8; j++) begin
      str_a[j] = 32'h1234_5678 * (j + 1);
      str_b[j] = 32'h0F0F_0F0F + 32'h0101_0101 * j;
      str_s[j] = j[0];
    end
    repeat (STAGES + 2) @(posedge clk);
    idx  = 0;
    base = popped;
    for (int i = 0; i < 40 && idx < 8; i++) begin
      @(posedge clk); #1;
      bus.out_ready = !(i >= 6 && i <= 8);
      bus.in_valid  = 1'b1;
      bus.op1       = str_a[idx];
      bus.op2       = str_b[idx];
      bus.sub       = str_s[idx];
      exp_rdy       = !(i >= 6 && i <= 8);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL stream_in_ready: cycle %0d got %b, required %b", i, bus.in_ready, exp_rdy);
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(negedge clk);
    checks++;
    if (popped - base != 8 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL stream_count: got %0d results (%0d pending), required 8 (0 pending)",
               popped - base, exp_q.size());
    end

    // Reset with ops in flight: five ops issued, reset after the first result appears.
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op1      = 32'd100 + j;
      bus.op2      = 32'd7;
      bus.sub      = 1'b0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_in_flight: got out_valid=%b r=%h, required 0 and 0",
               bus.out_valid, bus.result);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stale_after_reset: cycle %0d got out_valid=1, required 0", i);
      end
    end
    applyStimulus(32'd15, 32'd10, 1'b0);
    checkOutput("after_reset", 32'd25, 1'b0, 1'b0, 1'b0);

    // Random operands with random source gaps and consumer stalls, checked by the model.
    rnd_acc  = 0;
    accepted = 1;
    for (int i = 0; i < 4000 && rnd_acc < 400; i++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || accepted) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.op1      = rand_operand();
        bus.op2      = rand_operand();
        bus.sub      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) rnd_acc++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(negedge clk);
    checks++;
    if (rnd_acc != 400 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL random_drain: got %0d accepted, %0d pending, required 400 and 0",
               rnd_acc, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
